// File: rtl/regex_pkg.sv
// Shared types for the regex stream controller: sequencer state encoding and default record width.
`timescale 1ns/1ps
package regex_pkg;

  localparam int unsigned DefWidth = 21;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StShift,
    StSettle,
    StReport
  } state_e;

endpackage

// File: rtl/regex_bit_serializer.sv
// Load/shift register that presents a record MSB-first, one bit per shift cycle,
// and flags the cycle carrying the final bit.
`timescale 1ns/1ps
module regex_bit_serializer
  import regex_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             shift,
  output logic             bit_out,
  output logic             last_bit
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= data;
      cnt_q  <= '0;
    end else if (shift) begin
      sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign bit_out  = sreg_q[WIDTH-1];
  assign last_bit = shift & (cnt_q == LastCnt);

endmodule

// File: rtl/regex_stream_ctrl.sv
// Sequencer feeding the bit-serial regex matcher: accept record, optional matcher clear, shift,
// settle, report {match, index}. Define REGEX_MATCH_CNT_EN to add the saturating match_cnt port.
`timescale 1ns/1ps
module regex_stream_ctrl
  import regex_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter int unsigned CLR_PER_REC = 1,
  parameter int unsigned IDXW        = 20
`ifdef REGEX_MATCH_CNT_EN
  ,
  parameter int unsigned CNTW        = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic [WIDTH-1:0] rec_data,
  output logic             m_rst,
  output logic             m_en,
  output logic             m_bit,
  input  logic             m_match,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_match,
  output logic [IDXW-1:0]  res_index,
  output logic             busy
`ifdef REGEX_MATCH_CNT_EN
  ,
  output logic [CNTW-1:0]  match_cnt
`endif
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);

  state_e          state_q;
  logic [SW-1:0]   settle_q;
  logic [IDXW-1:0] idx_q;
  logic            abort_q;
  logic            accept;
  logic            ser_bit;
  logic            last_bit;

  assign rec_ready = (state_q == StIdle) & ~reset;
  assign accept    = rec_valid & rec_ready;

  regex_bit_serializer #(
    .WIDTH (WIDTH)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .data     (rec_data),
    .shift    (state_q == StShift),
    .bit_out  (ser_bit),
    .last_bit (last_bit)
  );

`ifdef REGEX_MATCH_CNT_EN
  logic [CNTW-1:0] match_q;
  assign match_cnt = match_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      idx_q     <= '0;
      abort_q   <= 1'b0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
`ifdef REGEX_MATCH_CNT_EN
      match_q   <= '0;
`endif
    end else begin
      abort_q <= 1'b0;
      // Abort flushes any in-flight record; the consumed index is kept.
      if (abort && (state_q != StIdle)) begin
        state_q   <= StIdle;
        res_valid <= 1'b0;
        abort_q   <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rec_valid) begin
              idx_q   <= idx_q + IDXW'(1);
              state_q <= (CLR_PER_REC != 0) ? StClear : StShift;
            end
          end
          StClear: state_q <= StShift;
          StShift: begin
            if (last_bit) begin
              state_q  <= StSettle;
              settle_q <= '0;
            end
          end
          StSettle: begin
            if (settle_q == SettleLast) begin
              state_q   <= StReport;
              res_valid <= 1'b1;
              res_match <= m_match;
            end else begin
              settle_q <= settle_q + SW'(1);
            end
          end
          StReport: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state_q   <= StIdle;
`ifdef REGEX_MATCH_CNT_EN
              if (res_match && (match_q != {CNTW{1'b1}})) match_q <= match_q + CNTW'(1);
`endif
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign m_rst     = reset | (state_q == StClear) | abort_q;
  assign m_en      = (state_q == StShift);
  assign m_bit     = m_en & ser_bit;
  assign res_index = idx_q;
  assign busy      = (state_q != StIdle);

endmodule
